// File: rtl/pes_fmul_arbiter_if.sv
// Requester-side handshake bundle for pes_fmul_arbiter: operand request
// channel and product response channel, one lane per requester.
interface pes_fmul_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ-1:0]    rsp_valid;
  logic [NREQ-1:0]    rsp_ready;
  logic [NREQ*32-1:0] rsp_data;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/pes_fmul_arbiter.sv
// Round-robin front end sharing one pipelined pes_fmul among NREQ requesters;
// tags ride alongside the multiplier pipeline and steer each product home.
module pes_fmul_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  pes_fmul_arbiter_if.slave bus,
  output logic [31:0]       mul_a,
  output logic [31:0]       mul_b,
  input  logic [31:0]       mul_c,
  output logic              busy
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    pending_r;
  logic [NREQ-1:0]    rsp_valid_r;
  logic [NREQ*32-1:0] rsp_data_r;
  logic [IW-1:0]      rr_ptr_r;
  logic [LAT-1:0]     tag_vld_r;
  logic [IW-1:0]      tag_idx_r [LAT];

  logic [NREQ-1:0]    eligible_s;
  logic [NREQ-1:0]    grant_s;
  logic [NREQ-1:0]    accept_s;
  logic [IW-1:0]      grant_idx_s;
  logic [IW-1:0]      scan_idx_s;
  logic               issue_s;
  logic               found_s;
  logic               hit_s;
  logic               cap_vld_s;
  logic [IW-1:0]      cap_idx_s;

  function automatic logic [IW-1:0] wrap_idx(input int v);
    return IW'(v % NREQ);
  endfunction

  // Round-robin scan starting at rr_ptr; nothing is granted while in reset
  always_comb begin
    eligible_s  = bus.req_valid & ~pending_r;
    grant_s     = {NREQ{1'b0}};
    grant_idx_s = {IW{1'b0}};
    scan_idx_s  = {IW{1'b0}};
    found_s     = 1'b0;
    hit_s       = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx_s          = wrap_idx(int'(rr_ptr_r) + k);
      hit_s               = rst_n & ~found_s & eligible_s[scan_idx_s];
      grant_s[scan_idx_s] = hit_s;
      grant_idx_s         = hit_s ? scan_idx_s : grant_idx_s;
      found_s             = found_s | hit_s;
    end
    issue_s = found_s;
  end

  // Operand mux towards the multiplier; idle cycles present zeros
  always_comb begin
    if (issue_s) begin
      mul_a = bus.req_a[{grant_idx_s, 5'b00000} +: 32];
      mul_b = bus.req_b[{grant_idx_s, 5'b00000} +: 32];
    end else begin
      mul_a = 32'h0000_0000;
      mul_b = 32'h0000_0000;
    end
  end

  assign accept_s      = rsp_valid_r & bus.rsp_ready;
  assign cap_vld_s     = tag_vld_r[LAT-1];
  assign cap_idx_s     = tag_idx_r[LAT-1];
  assign bus.req_ready = grant_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rsp_data_r;
  // pending covers both in-flight tags and full response slots
  assign busy          = |pending_r;

  // Tag pipeline, per-requester pending bits and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= {NREQ{1'b0}};
      rr_ptr_r  <= {IW{1'b0}};
      tag_vld_r <= {LAT{1'b0}};
      for (int s = 0; s < LAT; s++) begin
        tag_idx_r[s] <= {IW{1'b0}};
      end
    end else begin
      tag_vld_r[0] <= issue_s;
      tag_idx_r[0] <= grant_idx_s;
      for (int s = 1; s < LAT; s++) begin
        tag_vld_r[s] <= tag_vld_r[s-1];
        tag_idx_r[s] <= tag_idx_r[s-1];
      end
      pending_r <= (pending_r & ~accept_s) | grant_s;
      if (issue_s) begin
        rr_ptr_r <= wrap_idx(int'(grant_idx_s) + 1);
      end
    end
  end

  // Response slots: the pending bit guarantees the slot is empty on capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r <= {NREQ{1'b0}};
      rsp_data_r  <= {(NREQ*32){1'b0}};
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (cap_vld_s && (cap_idx_s == IW'(i))) begin
          rsp_valid_r[i]          <= 1'b1;
          rsp_data_r[32*i +: 32]  <= mul_c;
        end else if (accept_s[i]) begin
          rsp_valid_r[i]          <= 1'b0;
          rsp_data_r[32*i +: 32]  <= 32'h0000_0000;
        end
      end
    end
  end
endmodule

// File: tb/tb_pes_fmul_arbiter.sv
// Bench for pes_fmul_arbiter: directed cycle table, hand-written corner
// sequences and randomized traffic against a transaction-level model.
module tb_pes_fmul_arbiter;
  localparam int NREQ = 4;
  localparam int LAT  = 2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] mul_a, mul_b, mul_c, mstage;
  logic        busy;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [3:0]  v;
    logic [3:0]  er;
    logic [3:0]  rv;
    logic [31:0] val;
  } vec_t;
  vec_t tbl[$];

  typedef struct {
    int          idx;
    logic [31:0] p;
    int          due;
  } fl_t;
  fl_t             m_q[$];
  logic [NREQ-1:0] m_pend, m_sv;
  logic [31:0]     m_sd [NREQ];
  int              m_rr;

  pes_fmul_arbiter_if #(.NREQ(NREQ)) bus ();

  pes_fmul_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .mul_a (mul_a),
    .mul_b (mul_b),
    .mul_c (mul_c),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Single-precision product via double arithmetic, truncated (normals/zero only)
  function automatic logic [31:0] fmul_model(input logic [31:0] a, input logic [31:0] b);
    logic [10:0] ea, eb, ep;
    logic [63:0] d;
    real ra, rb;
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {a[31] ^ b[31], 31'h0};
    ea = {3'b000, a[30:23]} + 11'd896;
    eb = {3'b000, b[30:23]} + 11'd896;
    ra = $bitstoreal({a[31], ea, a[22:0], 29'h0});
    rb = $bitstoreal({b[31], eb, b[22:0], 29'h0});
    d  = $realtobits(ra * rb);
    ep = d[62:52] - 11'd896;
    return {d[63], ep[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] rand_fp();
    if ($urandom_range(0, 7) == 0) return 32'h0;
    return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
  endfunction

  // Stand-in for pes_fmul: two register stages, no reset
  always_ff @(posedge clk) begin
    mstage <= fmul_model(mul_a, mul_b);
    mul_c  <= mstage;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    bus.req_a[32*i +: 32] = a;
    bus.req_b[32*i +: 32] = b;
  endtask

  task automatic reset_dut();
    tick();
    rst_n         = 1'b0;
    bus.req_valid = 4'b1111;
    bus.rsp_ready = 4'b0000;
    @(negedge clk);
    chk("reset_req_ready", 128'(bus.req_ready), 128'h0);
    chk("reset_rsp_valid", 128'(bus.rsp_valid), 128'h0);
    chk("reset_rsp_data", 128'(bus.rsp_data), 128'h0);
    chk("reset_busy", 128'(busy), 128'h0);
    tick();
    bus.req_valid = 4'b0000;
    bus.rsp_ready = 4'b1111;
    rst_n         = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] exp_d;
    int           n1, g, last_g;
    logic [31:0]  ga, gb;

    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = '0;

    // cycle table: req_valid, expected req_ready, expected rsp_valid, slot value
    tbl.push_back('{4'b1111, 4'b0001, 4'b0000, 32'h0});
    tbl.push_back('{4'b1110, 4'b0010, 4'b0000, 32'h0});
    tbl.push_back('{4'b1100, 4'b0100, 4'b0000, 32'h0});
    tbl.push_back('{4'b1000, 4'b1000, 4'b0001, 32'h40400000});
    tbl.push_back('{4'b0000, 4'b0000, 4'b0010, 32'h40C00000});
    tbl.push_back('{4'b0000, 4'b0000, 4'b0100, 32'h41400000});
    tbl.push_back('{4'b0000, 4'b0000, 4'b1000, 32'h41C00000});
    tbl.push_back('{4'b0000, 4'b0000, 4'b0000, 32'h0});
    tbl.push_back('{4'b0010, 4'b0010, 4'b0000, 32'h0});
    tbl.push_back('{4'b0000, 4'b0000, 4'b0000, 32'h0});
    tbl.push_back('{4'b0000, 4'b0000, 4'b0000, 32'h0});
    tbl.push_back('{4'b0000, 4'b0000, 4'b0010, 32'h40C00000});
    tbl.push_back('{4'b0011, 4'b0001, 4'b0000, 32'h0});
    tbl.push_back('{4'b0010, 4'b0010, 4'b0000, 32'h0});
    tbl.push_back('{4'b0000, 4'b0000, 4'b0000, 32'h0});
    tbl.push_back('{4'b0000, 4'b0000, 4'b0001, 32'h40400000});
    tbl.push_back('{4'b0000, 4'b0000, 4'b0010, 32'h40C00000});
    tbl.push_back('{4'b0000, 4'b0000, 4'b0000, 32'h0});
    tbl.push_back('{4'b1111, 4'b0100, 4'b0000, 32'h0});
    tbl.push_back('{4'b1011, 4'b1000, 4'b0000, 32'h0});
    tbl.push_back('{4'b0011, 4'b0001, 4'b0000, 32'h0});
    tbl.push_back('{4'b0010, 4'b0010, 4'b0100, 32'h41400000});
    tbl.push_back('{4'b0000, 4'b0000, 4'b1000, 32'h41C00000});
    tbl.push_back('{4'b0000, 4'b0000, 4'b0001, 32'h40400000});
    tbl.push_back('{4'b0000, 4'b0000, 4'b0010, 32'h40C00000});
    tbl.push_back('{4'b0000, 4'b0000, 4'b0000, 32'h0});

    // single request: 3.0 * 2.0 returns three cycles after issue
    reset_dut();
    tick();
    set_ops(0, 32'h40400000, 32'h40000000);
    bus.req_valid = 4'b0001;
    @(negedge clk);
    chk("t1_grant", 128'(bus.req_ready), 128'h1);
    chk("t1_mul_a", 128'(mul_a), 128'h40400000);
    chk("t1_busy_issue_cycle", 128'(busy), 128'h0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      bus.req_valid = 4'b0000;
      @(negedge clk);
      chk($sformatf("t1_rsp_valid_c%0d", k), 128'(bus.rsp_valid), (k == 3) ? 128'h1 : 128'h0);
      if (k == 3) chk("t1_rsp_data", 128'(bus.rsp_data[31:0]), 128'h40C00000);
    end

    // table: burst from all requesters, wrap-around from rr_ptr=2
    reset_dut();
    for (int i = 0; i < NREQ; i++) set_ops(i, 32'h3F800000 + 32'(i) * 32'h00800000, 32'h40400000);
    for (int n = 0; n < tbl.size(); n++) begin
      tick();
      bus.req_valid = tbl[n].v;
      bus.rsp_ready = 4'b1111;
      @(negedge clk);
      exp_d = '0;
      for (int i = 0; i < NREQ; i++) if (tbl[n].rv[i]) exp_d[32*i +: 32] = tbl[n].val;
      chk($sformatf("tbl%0d_req_ready", n), 128'(bus.req_ready), 128'(tbl[n].er));
      chk($sformatf("tbl%0d_rsp_valid", n), 128'(bus.rsp_valid), 128'(tbl[n].rv));
      chk($sformatf("tbl%0d_rsp_data", n), bus.rsp_data, exp_d);
    end

    // stalled response 0 blocks requester 0 while requester 1 keeps issuing
    reset_dut();
    set_ops(0, 32'h40400000, 32'h3F800000);
    set_ops(1, 32'h40000000, 32'h40400000);
    n1 = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      bus.req_valid = 4'b0011;
      bus.rsp_ready = 4'b1110;
      @(negedge clk);
      if (bus.req_ready[1]) n1++;
      if (k == 0) chk("t3_first_grant", 128'(bus.req_ready), 128'h1);
      if (k >= 1) chk($sformatf("t3_ready0_c%0d", k), 128'(bus.req_ready[0]), 128'h0);
      if (k >= 3) begin
        chk($sformatf("t3_hold_valid_c%0d", k), 128'(bus.rsp_valid[0]), 128'h1);
        chk($sformatf("t3_hold_data_c%0d", k), 128'(bus.rsp_data[31:0]), 128'h40400000);
      end
    end
    chk("t3_req1_issues", 128'(n1), 128'd3);
    tick();
    bus.rsp_ready = 4'b1111;
    @(negedge clk);
    chk("t3_valid_at_accept", 128'(bus.rsp_valid[0]), 128'h1);
    tick();
    @(negedge clk);
    chk("t3_regrant0", 128'(bus.req_ready), 128'h1);
    tick();
    bus.req_valid = 4'b0000;

    // reset with an operation in flight
    reset_dut();
    tick();
    set_ops(1, 32'h40000000, 32'h40400000);
    bus.req_valid = 4'b0010;
    @(negedge clk);
    chk("t5_grant1", 128'(bus.req_ready), 128'h2);
    tick();
    bus.req_valid = 4'b0010;
    rst_n         = 1'b0;
    @(negedge clk);
    chk("t5_ready_in_reset", 128'(bus.req_ready), 128'h0);
    chk("t5_busy_in_reset", 128'(busy), 128'h0);
    tick();
    bus.req_valid = 4'b0000;
    rst_n         = 1'b1;
    for (int k = 1; k <= LAT + 3; k++) begin
      tick();
      @(negedge clk);
      chk($sformatf("t5_no_rsp_c%0d", k), 128'(bus.rsp_valid), 128'h0);
      chk($sformatf("t5_not_busy_c%0d", k), 128'(busy), 128'h0);
    end
    tick();
    bus.req_valid = 4'b1111;
    @(negedge clk);
    chk("t5_next_grant0", 128'(bus.req_ready), 128'h1);
    tick();
    bus.req_valid = 4'b0000;

    // zero operand passes through as a zero product
    reset_dut();
    tick();
    set_ops(3, 32'h00000000, 32'h3F800000);
    bus.req_valid = 4'b1000;
    @(negedge clk);
    chk("t6_grant3", 128'(bus.req_ready), 128'h8);
    for (int k = 1; k <= 4; k++) begin
      tick();
      bus.req_valid = 4'b0000;
      @(negedge clk);
      chk($sformatf("t6_rsp_valid_c%0d", k), 128'(bus.rsp_valid), (k == 3) ? 128'h8 : 128'h0);
      if (k == 3) chk("t6_rsp_data", 128'(bus.rsp_data[127:96]), 128'h0);
    end

    // randomized traffic against a transaction-level reference
    reset_dut();
    m_pend = '0;
    m_sv   = '0;
    m_rr   = 0;
    for (int i = 0; i < NREQ; i++) m_sd[i] = 32'h0;
    m_q.delete();
    last_g = -1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (last_g == i) bus.req_valid[i] = 1'b0;
        if (!bus.req_valid[i] && $urandom_range(0, 1) == 1) begin
          bus.req_valid[i] = 1'b1;
          set_ops(i, rand_fp(), rand_fp());
        end
        bus.rsp_ready[i] = ($urandom_range(0, 3) != 0);
      end
      @(negedge clk);
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (m_rr + k) % NREQ;
        if (g < 0 && bus.req_valid[j] && !m_pend[j]) g = j;
      end
      exp_d = '0;
      for (int i = 0; i < NREQ; i++) if (m_sv[i]) exp_d[32*i +: 32] = m_sd[i];
      ga = (g >= 0) ? bus.req_a[32*g +: 32] : 32'h0;
      gb = (g >= 0) ? bus.req_b[32*g +: 32] : 32'h0;
      chk("rnd_req_ready", 128'(bus.req_ready), (g >= 0) ? (128'h1 << g) : 128'h0);
      chk("rnd_rsp_valid", 128'(bus.rsp_valid), 128'(m_sv));
      chk("rnd_rsp_data", bus.rsp_data, exp_d);
      chk("rnd_busy", 128'(busy), 128'(|m_pend));
      chk("rnd_mul_a", 128'(mul_a), 128'(ga));
      for (int i = 0; i < NREQ; i++) begin
        if (m_sv[i] && bus.rsp_ready[i]) begin
          m_sv[i]   = 1'b0;
          m_sd[i]   = 32'h0;
          m_pend[i] = 1'b0;
        end
      end
      if (m_q.size() > 0 && m_q[0].due == cyc) begin
        m_sv[m_q[0].idx] = 1'b1;
        m_sd[m_q[0].idx] = m_q[0].p;
        void'(m_q.pop_front());
      end
      if (g >= 0) begin
        m_pend[g] = 1'b1;
        m_rr      = (g + 1) % NREQ;
        m_q.push_back('{g, fmul_model(ga, gb), cyc + LAT});
      end
      last_g = g;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
